// File: rtl/flash_streamer.sv
// Streams a burst of words from a 16-word image memory to a ready/valid sink.
// Define FLASH_STREAMER_CHECKSUM_EN to build the running XOR checksum register.
module flash_streamer #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic          mem_rd_r, mem_rd_s;
  logic [AW:0]   remain_r, remain_s;
  logic [DW-1:0] out_data_r, out_data_s;
  logic          out_valid_r, out_valid_s;
  logic          out_last_r, out_last_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s     = state_r;
    mem_addr_s  = mem_addr_r;
    mem_rd_s    = 1'b0;
    remain_s    = remain_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    out_last_s  = out_last_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // done_r is high only in the cycle right after FINISH: a start there is dropped
        if (start && !done_r) begin
          busy_s   = 1'b1;
          remain_s = count;
          if (count != {(AW+1){1'b0}}) begin
            mem_addr_s = base_addr;
            mem_rd_s   = 1'b1;
            state_s    = READ;
          end else begin
            state_s = FINISH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s = CAPTURE;
      end
      CAPTURE: begin
        out_data_s  = mem_rdata;
        out_valid_s = 1'b1;
        out_last_s  = (remain_r == {{AW{1'b0}}, 1'b1});
        state_s     = PRESENT;
      end
      PRESENT: begin
        if (out_valid_r && out_ready) begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
          remain_s    = remain_r - {{AW{1'b0}}, 1'b1};
          if (remain_r != {{AW{1'b0}}, 1'b1}) begin
            mem_addr_s = mem_addr_r + AW'(1'b1);
            mem_rd_s   = 1'b1;
            state_s    = READ;
          end else begin
            state_s = FINISH;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      FINISH: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_r     <= IDLE;
      mem_addr_r  <= {AW{1'b0}};
      mem_rd_r    <= 1'b0;
      remain_r    <= {(AW+1){1'b0}};
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      mem_addr_r  <= mem_addr_s;
      mem_rd_r    <= mem_rd_s;
      remain_r    <= remain_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_rd    = mem_rd_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

`ifdef FLASH_STREAMER_CHECKSUM_EN
  logic [DW-1:0] checksum_r;
  logic          sum_clr_s;
  logic          sum_add_s;

  assign sum_clr_s = (state_r == IDLE) && start && !done_r;
  assign sum_add_s = (state_r == PRESENT) && out_valid_r && out_ready;

  // Running XOR of handed-off words; holds after done until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      checksum_r <= {DW{1'b0}};
    end else if (sum_clr_s) begin
      checksum_r <= {DW{1'b0}};
    end else if (sum_add_s) begin
      checksum_r <= checksum_r ^ out_data_r;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = {DW{1'b0}};
`endif

endmodule

// File: doc/flash_streamer.md
FLASH_STREAMER -- requirements
Module: flash_streamer

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter AW, default 4, word-address width (16-word image).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rstb  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  AW  first word address, captured on accepted start.
REQ-007 SHALL have port count  input  AW+1  number of words to stream (0..16), captured on accepted start.
REQ-008 SHALL have port mem_addr  output  AW  read address to the image memory.
REQ-009 SHALL have port mem_rd  output  1  read strobe; the memory returns mem_rdata exactly one cycle after mem_rd=1.
REQ-010 SHALL have port mem_rdata  input  DW  read data from the image memory.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the word when out_valid and out_ready are both 1.
REQ-013 SHALL have port out_data  output  DW  streamed word.
REQ-014 SHALL have port out_last  output  1  marks the final word of a burst; qualified by out_valid.
REQ-015 SHALL have port busy  output  1  1 from accepted start until the cycle done is asserted.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-017 SHALL have port checksum  output  DW  XOR of all words handed off in the current or most recent burst.

Function
REQ-018 SHALL implement states IDLE, READ, CAPTURE, PRESENT and FINISH.
REQ-019 IDLE: start=1 with count>0 SHALL capture base_addr and count, clear checksum, set busy and go to READ.
REQ-020 IDLE: start=1 with count=0 SHALL go to FINISH without issuing any read or asserting out_valid.
REQ-021 READ: SHALL drive mem_rd=1 and mem_addr=current address for exactly one cycle, then go to CAPTURE.
REQ-022 CAPTURE: SHALL register mem_rdata into out_data, set out_valid=1, set out_last=1 if the remaining count is 1, then go to PRESENT.
REQ-023 PRESENT: out_valid, out_data and out_last SHALL hold stable until handoff; an out_ready=1 sampled while out_valid=0 SHALL have no effect.
REQ-024 On handoff, the block SHALL XOR out_data into checksum, clear out_valid, increment the address modulo 2^AW, and decrement the remaining count.
REQ-025 After handoff, the block SHALL go to READ if the remaining count is nonzero, otherwise to FINISH.
REQ-026 FINISH: SHALL pulse done=1 for one cycle, clear busy in that same cycle, and return to IDLE.
REQ-027 Address wrap: base_addr=14 with count=4 SHALL read addresses 14, 15, 0, 1.
REQ-028 The minimum latency from accepted start to first out_valid SHALL be 3 cycles (IDLE to READ to CAPTURE to PRESENT); throughput SHALL be one word per 3 cycles with out_ready held at 1.
REQ-029 start asserted while busy=1 SHALL be ignored.
REQ-030 A start arriving in the same cycle done pulses SHALL be ignored; a new start is accepted from the following cycle.
REQ-031 mem_rd SHALL be 0 in every state except READ, and mem_addr SHALL hold its last value when mem_rd=0.

Reset
REQ-032 On a clock edge with rstb=0, the block SHALL enter IDLE and clear out_valid, out_last, busy, done, mem_rd, mem_addr, out_data and checksum to 0.
REQ-033 Reset mid-burst SHALL abort the burst with no done pulse; the first cycle after rstb returns to 1 SHALL behave as IDLE.

Configuration
REQ-034 Macro FLASH_STREAMER_CHECKSUM_EN SHALL select the checksum logic.
REQ-035 With FLASH_STREAMER_CHECKSUM_EN defined, checksum SHALL behave per REQ-017, REQ-019 and REQ-024 and hold its value after done until the next accepted start.
REQ-036 Without FLASH_STREAMER_CHECKSUM_EN, the checksum port SHALL remain present, SHALL be constant 0, and no checksum register SHALL be synthesized.

Verification
REQ-037 Bench scenario: memory word[i]=0x1000_0000+i, base_addr=0, count=4, out_ready=1 -> out_data 0x10000000..0x10000003, out_last only on the 4th word, done once, checksum=0x00000000.
REQ-038 Bench scenario: base_addr=14, count=3, memory words 14/15/0 = 0xAAAA0000/0x5555FFFF/0x00000001 -> mem_addr sequence 14, 15, 0 and checksum=0xFFFFFFFE.
REQ-039 Bench scenario: count=0 start -> no mem_rd, no out_valid, done pulse exactly 2 cycles after start.
REQ-040 Bench scenario: out_ready held at 0 for 10 cycles on word 2 -> out_data stable and no extra mem_rd while stalled; the stream resumes correctly when out_ready=1.
REQ-041 Bench scenario: start pulsed again mid-burst, then rstb=0 for 1 cycle after the 2nd word -> second start ignored, no done pulse, outputs zero, and a new burst runs cleanly after reset.
REQ-042 Bench scenario: build without FLASH_STREAMER_CHECKSUM_EN and rerun REQ-037 -> identical stream and checksum=0 throughout.
